// File: rtl/arbitro_bandas.sv
// Round-robin scheduler for the band painter. It queues pad hits and issues one
// legal one-hot command per cycle: start, then static band, then one drum band at a time.
module arbitro_bandas #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic [4:0]  golpe,
  output logic [6:0]  entrada,
  output logic [2:0]  banda_activa,
  output logic [4:0]  pendientes,
  output logic [15:0] grant_count
);

  typedef enum logic [1:0] {IDLE, ARRANQUE, ESTATICA, BANDA} estado_t;

  // Counters hold "cycles remaining after this one", so each phase lasts LOAD+1 cycles.
  localparam logic [7:0] HOLD_LD = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] GAP_LD  = 8'(GAP_CYCLES - 1);

  estado_t     state, state_n;
  logic [7:0]  cnt, cnt_n;
  logic [2:0]  ptr, ptr_n;
  logic [2:0]  banda_n, sel;
  logic [4:0]  pend_n, clr;
  logic [6:0]  entrada_n;
  logic        fin_grant;

  // First requesting pad at or after base, wrapping 4 -> 0; 7 when none request.
  function automatic logic [2:0] pick_pad(input logic [4:0] req, input logic [2:0] base);
    logic [2:0] pad;
    logic       hit;
    logic [3:0] idx;
    pad = 3'd7;
    hit = 1'b0;
    for (int i = 0; i < 5; i++) begin
      idx = {1'b0, base} + 4'(i);
      if (idx >= 4'd5) idx = idx - 4'd5;
      if (!hit && req[idx[2:0]]) begin
        pad = idx[2:0];
        hit = 1'b1;
      end
    end
    return pad;
  endfunction

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    ptr_n     = ptr;
    banda_n   = banda_activa;
    clr       = 5'b0;
    fin_grant = 1'b0;
    sel       = pick_pad(pendientes, ptr);

    case (state)
      IDLE: begin
        banda_n = 3'd7;
        if (start) state_n = ARRANQUE;
      end
      ARRANQUE: begin
        state_n = ESTATICA;
        cnt_n   = GAP_LD;
      end
      ESTATICA: begin
        if (cnt != 8'd0) begin
          cnt_n = cnt - 8'd1;
        end else if (pendientes != 5'd0) begin
          state_n = BANDA;
          cnt_n   = HOLD_LD;
          banda_n = sel;
        end
      end
      BANDA: begin
        if (cnt != 8'd0) begin
          cnt_n = cnt - 8'd1;
        end else begin
          state_n   = ESTATICA;
          cnt_n     = GAP_LD;
          clr       = 5'b00001 << banda_activa;
          ptr_n     = (banda_activa == 3'd4) ? 3'd0 : banda_activa + 3'd1;
          banda_n   = 3'd7;
          fin_grant = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // A re-hit on the clearing edge is OR-ed in after the clear, so it stays queued.
    pend_n = (state == IDLE) ? 5'd0 : ((pendientes & ~clr) | golpe);

    if (stop) begin
      state_n   = IDLE;
      cnt_n     = 8'd0;
      ptr_n     = 3'd0;
      pend_n    = 5'd0;
      banda_n   = 3'd7;
      fin_grant = 1'b0;
    end

    case (state_n)
      ARRANQUE: entrada_n = 7'b0000001;
      ESTATICA: entrada_n = 7'b0000010;
      BANDA:    entrada_n = 7'b0000100 << banda_n;
      default:  entrada_n = 7'b0000000;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= 8'd0;
      ptr          <= 3'd0;
      pendientes   <= 5'd0;
      banda_activa <= 3'd7;
      entrada      <= 7'd0;
      grant_count  <= 16'd0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      ptr          <= ptr_n;
      pendientes   <= pend_n;
      banda_activa <= banda_n;
      entrada      <= entrada_n;
      grant_count  <= grant_count + {15'd0, fin_grant};
    end
  end

endmodule

// File: doc/arbitro_bandas.md
# arbitro_bandas

Round-robin scheduler for the band painter state machine. It collects drum-pad hits from five pads, arbitrates among them, and drives the painter's 7-bit one-hot command bus. The command sequence is start, then static band, then exactly one drum band at a time, each held for a fixed number of cycles. It sits between the pad sensor conditioning and the painter, so the painter always sees a legal, stable command word.

## Interface
- HOLD_CYCLES, 4: cycles a granted band command is held; legal range 1..255.
- GAP_CYCLES, 1: minimum cycles of static-band command between grants; legal range 1..255.

- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high.
- start  input  1  game start request, sampled while IDLE.
- stop  input  1  synchronous abort; returns to IDLE and clears all pending hits.
- golpe  input  5  pad hit requests, bit k = pad k; level-sampled every edge.
- entrada  output  7  registered command to the painter: bit0 start, bit1 static band, bit 2+k band k.
- banda_activa  output  3  index of the granted pad (0..4); 7 when no band is granted.
- pendientes  output  5  registered pending-hit vector.
- grant_count  output  16  registered count of completed grants; wraps 0xFFFF to 0.

## Operation
- States: IDLE, ARRANQUE, ESTATICA, BANDA.
- IDLE
  - entrada = 0, banda_activa = 7.
  - If start=1 at an edge, the next state is ARRANQUE.
  - golpe is ignored; pendientes stays 0.
- ARRANQUE
  - entrada = 7'b0000001 for exactly one cycle, then ESTATICA.
- ESTATICA
  - entrada = 7'b0000010, counter loaded with GAP_CYCLES.
  - Stays in ESTATICA while the counter is nonzero.
  - When the counter expires:
    - pendientes != 0 → BANDA, granting the first set bit searched from ptr upward with wrap (ptr, ptr+1, …, 4, 0, …).
    - pendientes == 0 → remains in ESTATICA, re-evaluating every cycle.
- BANDA
  - entrada = 1 << (2+k), banda_activa = k, held for HOLD_CYCLES cycles.
  - On exit:
    - pendientes[k] is cleared.
    - ptr = (k+1) mod 5; 4 wraps to 0.
    - grant_count increments.
    - Next state is ESTATICA.
- Pending capture: from ARRANQUE onward, pendientes |= golpe at every edge.
  - If pendientes[k] is cleared on the same edge golpe[k]=1, the set wins (a re-hit during its own grant is queued again).
- Arbitration uses the registered pendientes value, not the same-edge golpe.
- entrada is always one-hot or zero; no cycle ever shows two bits set.
- stop=1 at any edge outside IDLE:
  - next state IDLE, pendientes = 0, ptr = 0, entrada = 0.
  - grant_count is kept; an aborted grant is not counted.
  - stop has priority over start and golpe.
- reset (asynchronous) forces the following immediately, independent of clk:
  - state IDLE, entrada = 0, banda_activa = 7, pendientes = 0, ptr = 0, counter = 0, grant_count = 0.
- HOLD/GAP counters are 8-bit. A grant and the static gap are never shortened by new hits.

## Timing
- Cycle n means the interval after edge n.
- start=1 at edge 0 gives:
  - cycle 1: entrada=0000001.
  - cycles 2..1+GAP_CYCLES: entrada=0000010.
- Grant latency: a hit registered at edge e is granted no earlier than the first ESTATICA-expiry edge after e.
  - Minimum: hit pending before expiry edge x → band command in cycle x.
- A grant occupies exactly HOLD_CYCLES cycles, followed by at least GAP_CYCLES cycles of 0000010.
  - Steady-state throughput: one grant per HOLD_CYCLES+GAP_CYCLES cycles.
- Worst-case wait of a pending pad: 4 other grants, i.e. 4·(HOLD_CYCLES+GAP_CYCLES) cycles after the current gap.
- All outputs change only on clk edges, except on reset assertion.

## Test plan
GAP_CYCLES=1, HOLD_CYCLES=4 unless noted.
- **Reset:** assert reset mid-cycle during BANDA → entrada=0, banda_activa=7, pendientes=0, grant_count=0 immediately, without waiting for a clock edge; after release, outputs stay idle until start.
- **Start and single hit:**
  - Stimulus: start at edge 0, golpe=00001 for one cycle at edge 1.
  - Response:
    - cycle 1: entrada=0000001.
    - cycle 2: 0000010.
    - cycles 3-6: 0000100, banda_activa=0.
    - cycle 7: 0000010.
    - grant_count=1, pendientes=0.
- **Simultaneous hits:** golpe=10101 for one cycle, ptr=0 → grants in order pads 0, 2, 4, each 4 cycles with a 1-cycle 0000010 gap between; grant_count=3 at the end.
- **Wrap-around:** after a pad 3 grant (ptr=4), pending 10001 → pad 4 first, then pad 0; ptr ends at 1.
- **Re-hit during own grant:**
  - Stimulus: golpe[2]=1 on the last BANDA edge of the pad 2 grant, with pad 4 also pending.
  - Response: pendientes[2] stays 1; pad 4 is granted next, then pad 2 again.
- **Abort:**
  - Stimulus: stop=1 at the second edge of a grant, with golpe=11111 applied at the same edge.
  - Response: next cycle entrada=0, pendientes=0, grant_count unchanged; a new start restarts at ARRANQUE with ptr=0.
